// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller and the control unit:
// CSR addresses, PC source encodings, trap cause codes and the FSM state type.
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;
   localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

   localparam logic [2:0] PCSEL_NEXT   = 3'd0;
   localparam logic [2:0] PCSEL_JALR   = 3'd1;
   localparam logic [2:0] PCSEL_BRANCH = 3'd2;
   localparam logic [2:0] PCSEL_JAL    = 3'd3;
   localparam logic [2:0] PCSEL_MTVEC  = 3'd4;
   localparam logic [2:0] PCSEL_MEPC   = 3'd5;

   localparam logic [31:0] CAUSE_ILLEGAL_INSTR = 32'd2;
   localparam logic [31:0] CAUSE_ECALL_M       = 32'd11;
   localparam logic [31:0] CAUSE_MEXT_IRQ      = 32'h8000_000B;

   typedef enum logic {StRun, StFlush} trap_state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit-side bus between the control unit (master) and the trap controller (slave).
interface trap_ctrl_if;
   logic        instr_valid;
   logic [31:0] pc_addr;
   logic        illegal_instr;
   logic        ecall;
   logic        mret;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic [2:0]  pc_src_sel;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        trap_taken;
   logic        flush;

   modport master (
      output instr_valid, pc_addr, illegal_instr, ecall, mret, csr_we, csr_addr, csr_wdata,
      input  csr_rdata, pc_src_sel, mtvec, mepc, trap_taken, flush
   );

   modport slave (
      input  instr_valid, pc_addr, illegal_instr, ecall, mret, csr_we, csr_addr, csr_wdata,
      output csr_rdata, pc_src_sel, mtvec, mepc, trap_taken, flush
   );
endinterface

// File: rtl/irq_sync.sv
// Flop-chain synchronizer for an asynchronous level input, cleared on reset.
module irq_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap and CSR controller: accepts trap/mret events at commit, owns the
// M-mode CSRs and mcycle, and steers the PC to mtvec or mepc.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        intr,
   trap_ctrl_if.slave  bus
);

   trap_state_e state_q, state_d;
   logic        mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d;
   logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
   logic [63:0] mcycle_q, mcycle_d;

   logic        intr_s, irq_pend, accept, trap, irq_trap, mret_ev, hw_ev, csr_wr;
   logic [31:0] cause;

   irq_sync #(
      .STAGES (SYNC_STAGES)
   ) u_irq_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (intr),
      .q     (intr_s)
   );

   // Nothing is accepted in FLUSH; a pending interrupt simply waits for the next commit.
   assign irq_pend = intr_s & mie_q & meie_q;
   assign accept   = (state_q == StRun) & bus.instr_valid;
   assign trap     = accept & (bus.illegal_instr | bus.ecall | irq_pend);
   assign irq_trap = accept & ~bus.illegal_instr & ~bus.ecall & irq_pend;
   assign mret_ev  = accept & bus.mret & ~bus.illegal_instr & ~bus.ecall & ~irq_pend;
   assign hw_ev    = trap | mret_ev;
   // An interrupted instruction never executed, so its CSR write must not land.
   assign csr_wr   = accept & bus.csr_we & ~irq_trap;

   assign cause = bus.illegal_instr ? CAUSE_ILLEGAL_INSTR :
                  bus.ecall         ? CAUSE_ECALL_M       : CAUSE_MEXT_IRQ;

   always_comb begin
      state_d = state_q;
      if (hw_ev) begin
         state_d = StFlush;
      end else if (state_q == StFlush) begin
         state_d = StRun;
      end
   end

   always_comb begin
      mie_d    = mie_q;
      mpie_d   = mpie_q;
      meie_d   = meie_q;
      mtvec_d  = mtvec_q;
      mepc_d   = mepc_q;
      mcause_d = mcause_q;
      mcycle_d = mcycle_q + 64'd1;

      if (csr_wr) begin
         case (bus.csr_addr)
            CSR_MSTATUS: begin
               if (!hw_ev) begin
                  mie_d  = bus.csr_wdata[3];
                  mpie_d = bus.csr_wdata[7];
               end
            end
            CSR_MIE:     meie_d  = bus.csr_wdata[11];
            CSR_MTVEC:   mtvec_d = bus.csr_wdata & ~32'h3;
            CSR_MEPC:    if (!hw_ev) mepc_d = bus.csr_wdata & ~32'h3;
            CSR_MCAUSE:  if (!hw_ev) mcause_d = bus.csr_wdata;
            CSR_MCYCLE:  mcycle_d = {mcycle_q[63:32], bus.csr_wdata};
            CSR_MCYCLEH: mcycle_d = {bus.csr_wdata, mcycle_q[31:0]};
            default: ;
         endcase
      end

      if (trap) begin
         mepc_d   = bus.pc_addr & ~32'h3;
         mcause_d = cause;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret_ev) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StRun;
         mie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         meie_q   <= 1'b0;
         mtvec_q  <= MTVEC_RESET & ~32'h3;
         mepc_q   <= '0;
         mcause_q <= '0;
         mcycle_q <= '0;
      end else begin
         state_q  <= state_d;
         mie_q    <= mie_d;
         mpie_q   <= mpie_d;
         meie_q   <= meie_d;
         mtvec_q  <= mtvec_d;
         mepc_q   <= mepc_d;
         mcause_q <= mcause_d;
         mcycle_q <= mcycle_d;
      end
   end

   always_comb begin
      bus.csr_rdata = '0;
      case (bus.csr_addr)
         CSR_MSTATUS: begin
            bus.csr_rdata[3] = mie_q;
            bus.csr_rdata[7] = mpie_q;
         end
         CSR_MIE:     bus.csr_rdata[11] = meie_q;
         CSR_MTVEC:   bus.csr_rdata = mtvec_q;
         CSR_MEPC:    bus.csr_rdata = mepc_q;
         CSR_MCAUSE:  bus.csr_rdata = mcause_q;
         CSR_MIP:     bus.csr_rdata[11] = intr_s;
         CSR_MCYCLE:  bus.csr_rdata = mcycle_q[31:0];
         CSR_MCYCLEH: bus.csr_rdata = mcycle_q[63:32];
         default: ;
      endcase
   end

   assign bus.pc_src_sel = trap ? PCSEL_MTVEC : (mret_ev ? PCSEL_MEPC : PCSEL_NEXT);
   assign bus.trap_taken = trap;
   assign bus.flush      = (state_q == StFlush);
   assign bus.mtvec      = mtvec_q;
   assign bus.mepc       = mepc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios with literal expectations, then random commits
// checked every cycle against a behavioural model of the trap/CSR rules.
module tb_trap_ctrl;

   localparam int unsigned SYNC = 2;

   logic clk;
   logic rst_n;
   logic intr;
   int   checks;
   int   failures;

   trap_ctrl_if bus ();

   trap_ctrl #(
      .MTVEC_RESET (32'h0000_1003),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .intr  (intr),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model state
   bit          m_mie, m_mpie, m_meie, m_fl;
   logic [31:0] m_mtvec, m_mepc, m_mcause;
   logic [63:0] m_cyc;
   bit          hist[$];

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_meie = 0; m_fl = 0;
      m_mtvec = 32'h0000_1000; m_mepc = 0; m_mcause = 0; m_cyc = 0;
      hist.delete();
   endtask

   function automatic bit model_intr_s();
      if (hist.size() < SYNC) return 1'b0;
      return hist[hist.size() - SYNC];
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] a);
      case (a)
         12'h300: return {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
         12'h304: return m_meie ? 32'h800 : 32'h0;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h344: return model_intr_s() ? 32'h800 : 32'h0;
         12'hB00: return m_cyc[31:0];
         12'hB80: return m_cyc[63:32];
         default: return 32'h0;
      endcase
   endfunction

   // Compare process: expected outputs at each negedge, model advances at each posedge.
   initial begin
      bit          n_mie, n_mpie, n_meie, n_fl;
      logic [31:0] n_mtvec, n_mepc, n_mcause, e_cause;
      logic [63:0] n_cyc;
      int          kind;  // 0 none, 1 synchronous trap, 2 interrupt, 3 mret
      logic [2:0]  e_sel;
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         kind = 0;
         e_cause = 0;
         if (!m_fl && bus.instr_valid) begin
            if (bus.illegal_instr) begin kind = 1; e_cause = 32'd2; end
            else if (bus.ecall) begin kind = 1; e_cause = 32'd11; end
            else if (model_intr_s() && m_mie && m_meie) begin kind = 2; e_cause = 32'h8000_000B; end
            else if (bus.mret) kind = 3;
         end
         e_sel = (kind == 1 || kind == 2) ? 3'd4 : (kind == 3 ? 3'd5 : 3'd0);
         chk("pc_src_sel", 64'(bus.pc_src_sel), 64'(e_sel));
         chk("trap_taken", 64'(bus.trap_taken), 64'(kind == 1 || kind == 2));
         chk("flush", 64'(bus.flush), 64'(m_fl));
         chk("mtvec", 64'(bus.mtvec), 64'(m_mtvec));
         chk("mepc", 64'(bus.mepc), 64'(m_mepc));
         chk("csr_rdata", 64'(bus.csr_rdata), 64'(model_read(bus.csr_addr)));

         n_mie = m_mie; n_mpie = m_mpie; n_meie = m_meie;
         n_mtvec = m_mtvec; n_mepc = m_mepc; n_mcause = m_mcause;
         n_cyc = m_cyc + 64'd1;
         if (!m_fl && bus.instr_valid && bus.csr_we && kind != 2) begin
            case (bus.csr_addr)
               12'h300: if (kind == 0) begin
                  n_mie = bus.csr_wdata[3]; n_mpie = bus.csr_wdata[7];
               end
               12'h304: n_meie = bus.csr_wdata[11];
               12'h305: n_mtvec = {bus.csr_wdata[31:2], 2'b00};
               12'h341: if (kind == 0) n_mepc = {bus.csr_wdata[31:2], 2'b00};
               12'h342: if (kind == 0) n_mcause = bus.csr_wdata;
               12'hB00: n_cyc = {m_cyc[63:32], bus.csr_wdata};
               12'hB80: n_cyc = {bus.csr_wdata, m_cyc[31:0]};
               default: ;
            endcase
         end
         if (kind == 1 || kind == 2) begin
            n_mepc = {bus.pc_addr[31:2], 2'b00};
            n_mcause = e_cause;
            n_mpie = m_mie;
            n_mie = 0;
         end else if (kind == 3) begin
            n_mie = m_mpie;
            n_mpie = 1;
         end
         n_fl = (kind != 0);

         @(posedge clk);
         if (rst_n) begin
            m_mie = n_mie; m_mpie = n_mpie; m_meie = n_meie; m_fl = n_fl;
            m_mtvec = n_mtvec; m_mepc = n_mepc; m_mcause = n_mcause; m_cyc = n_cyc;
            hist.push_back(intr);
            if (hist.size() > SYNC) void'(hist.pop_front());
         end
      end
   end

   task automatic drv(input bit v, input bit ill, input bit ec, input bit mr, input bit we,
                      input logic [11:0] addr, input logic [31:0] wd, input logic [31:0] pc);
      bus.instr_valid = v; bus.illegal_instr = ill; bus.ecall = ec; bus.mret = mr;
      bus.csr_we = we; bus.csr_addr = addr; bus.csr_wdata = wd; bus.pc_addr = pc;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [11:0] ADDRS [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                          12'h344, 12'hB00, 12'hB80, 12'h123, 12'hF14};

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      intr = 1'b0;
      drv(0, 0, 0, 0, 0, 12'h300, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mtvec", 64'(bus.mtvec), 64'h1000);
      chk("rst_mepc", 64'(bus.mepc), 64'h0);
      chk("rst_sel", 64'(bus.pc_src_sel), 64'h0);
      chk("rst_flush", 64'(bus.flush), 64'h0);
      chk("rst_mstatus", 64'(bus.csr_rdata), 64'h0);
      nxt();
      rst_n = 1'b1;

      // Illegal instruction trap, then an ecall offered during FLUSH
      drv(1, 0, 0, 0, 1, 12'h305, 32'h104, 32'h0); nxt();
      drv(1, 1, 0, 0, 0, 12'h342, 0, 32'h40);
      @(negedge clk);
      chk("ill_sel", 64'(bus.pc_src_sel), 64'h4);
      chk("ill_tt", 64'(bus.trap_taken), 64'h1);
      nxt();
      drv(1, 0, 1, 0, 0, 12'h342, 0, 32'h44);
      @(negedge clk);
      chk("ill_mepc", 64'(bus.mepc), 64'h40);
      chk("ill_mcause", 64'(bus.csr_rdata), 64'h2);
      chk("ill_flush", 64'(bus.flush), 64'h1);
      chk("flush_ign_sel", 64'(bus.pc_src_sel), 64'h0);
      chk("flush_ign_tt", 64'(bus.trap_taken), 64'h0);
      nxt();

      // External interrupt held pending across idle cycles
      drv(1, 0, 0, 0, 1, 12'h300, 32'h8, 32'h44); nxt();
      drv(1, 0, 0, 0, 1, 12'h304, 32'h800, 32'h48); nxt();
      intr = 1'b1;
      drv(0, 0, 0, 0, 0, 12'h344, 0, 0); nxt();
      nxt();
      @(negedge clk);
      chk("irq_mip", 64'(bus.csr_rdata), 64'h800);
      chk("irq_held_sel", 64'(bus.pc_src_sel), 64'h0);
      nxt();
      drv(1, 0, 0, 0, 1, 12'h305, 32'h999, 32'h80);
      @(negedge clk);
      chk("irq_sel", 64'(bus.pc_src_sel), 64'h4);
      chk("irq_tt", 64'(bus.trap_taken), 64'h1);
      nxt();
      drv(0, 0, 0, 0, 0, 12'h300, 0, 0);
      @(negedge clk);
      chk("irq_mepc", 64'(bus.mepc), 64'h80);
      chk("irq_mstatus", 64'(bus.csr_rdata), 64'h80);
      chk("irq_we_supp", 64'(bus.mtvec), 64'h104);
      nxt();
      intr = 1'b0;
      drv(1, 0, 0, 0, 0, 12'h342, 0, 32'h84);
      @(negedge clk);
      chk("irq_no_retrap", 64'(bus.pc_src_sel), 64'h0);
      chk("irq_mcause", 64'(bus.csr_rdata), 64'h8000_000B);
      nxt();

      // mret
      drv(1, 0, 0, 1, 0, 12'h300, 0, 32'h88);
      @(negedge clk);
      chk("mret_sel", 64'(bus.pc_src_sel), 64'h5);
      chk("mret_tt", 64'(bus.trap_taken), 64'h0);
      chk("mret_mepc", 64'(bus.mepc), 64'h80);
      chk("mret_mtvec", 64'(bus.mtvec), 64'h104);
      nxt();
      drv(0, 0, 0, 0, 0, 12'h300, 0, 0);
      @(negedge clk);
      chk("mret_mstatus", 64'(bus.csr_rdata), 64'h88);
      nxt();

      // Illegal + ecall + pending interrupt together
      intr = 1'b1;
      nxt();
      nxt();
      drv(1, 1, 1, 0, 0, 12'h342, 0, 32'h50);
      @(negedge clk);
      chk("simul_sel", 64'(bus.pc_src_sel), 64'h4);
      nxt();
      intr = 1'b0;
      drv(0, 0, 0, 0, 0, 12'h342, 0, 0);
      @(negedge clk);
      chk("simul_mcause", 64'(bus.csr_rdata), 64'h2);
      nxt();

      // CSR write to mepc loses to an ecall
      drv(1, 0, 1, 0, 1, 12'h341, 32'h200, 32'h60); nxt();
      drv(0, 0, 0, 0, 0, 12'h341, 0, 0);
      @(negedge clk);
      chk("ecall_mepc", 64'(bus.csr_rdata), 64'h60);
      nxt();

      // mcycle carry across halves
      drv(1, 0, 0, 0, 1, 12'hB00, 32'hFFFF_FFFF, 0); nxt();
      drv(1, 0, 0, 0, 1, 12'hB80, 32'h0, 0); nxt();
      drv(0, 0, 0, 0, 0, 12'hB00, 0, 0);
      @(negedge clk);
      chk("mcycle_lo_full", 64'(bus.csr_rdata), 64'hFFFF_FFFF);
      nxt();
      drv(0, 0, 0, 0, 0, 12'hB80, 0, 0);
      @(negedge clk);
      chk("mcycle_hi_carry", 64'(bus.csr_rdata), 64'h1);
      nxt();
      drv(0, 0, 0, 0, 0, 12'hB00, 0, 0);
      @(negedge clk);
      chk("mcycle_lo_wrap", 64'(bus.csr_rdata), 64'h1);
      nxt();

      // Random commits, checked by the model every cycle
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 7) == 0) intr = ~intr;
         drv($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 6) == 0, $urandom_range(0, 4) < 2,
             ADDRS[$urandom_range(0, 9)], $urandom, $urandom);
         nxt();
      end
      drv(0, 0, 0, 0, 0, 12'h300, 0, 0);
      repeat (3) nxt();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap and CSR controller. It originates the redirect requests that the program counter consumes. It samples the exception, ecall and mret events and the external interrupt at each instruction boundary, and updates mstatus, mepc and mcause. It drives the PC source select and the trap vector and return addresses, and owns the M-mode CSR file and the mcycle counter. It sits beside the control unit; its pc_src_sel, mtvec and mepc outputs connect directly to the PC's src_sel, mtvec and mepc inputs.

Parameters:
MTVEC_RESET, 32'h0000_0000, reset value of mtvec (bits [1:0] ignored, forced 0).
SYNC_STAGES, 2, flip-flop stages on the intr input (minimum 2).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
intr  in  1  external interrupt request, level, asynchronous.
instr_valid  in  1  high for one cycle when the instruction at pc_addr commits.
pc_addr  in  32  address of the committing instruction.
illegal_instr  in  1  committing instruction is illegal; qualified by instr_valid.
ecall  in  1  committing instruction is ECALL; qualified by instr_valid.
mret  in  1  committing instruction is MRET; qualified by instr_valid.
csr_we  in  1  CSR write strobe; qualified by instr_valid.
csr_addr  in  12  CSR address for read and write.
csr_wdata  in  32  CSR write data.
csr_rdata  out  32  combinational read data for csr_addr.
pc_src_sel  out  3  0 = sequential, 4 = mtvec, 5 = mepc.
mtvec  out  32  trap vector.
mepc  out  32  return address.
trap_taken  out  1  one-cycle pulse on trap entry.
flush  out  1  high during the FLUSH state; squashes the fetched instruction.

Behaviour:
- Reset (async, rst_n=0):
  - mstatus.MIE=0, mstatus.MPIE=0, mie=0, mepc=0, mcause=0, mcycle=0.
  - mtvec=MTVEC_RESET with bits [1:0]=0.
  - Synchronizer cleared; FSM=RUN; pc_src_sel=0; trap_taken=0; flush=0.
- Interrupt synchronizer: intr passes through SYNC_STAGES flops giving intr_s. irq_pend = intr_s & mstatus.MIE & mie[11].
- FSM states: RUN and FLUSH.
  - RUN to FLUSH on any accepted event: trap or mret.
  - FLUSH to RUN unconditionally after 1 cycle.
  - In FLUSH, instr_valid and all qualified inputs are ignored and no event is accepted.
- Event evaluation in RUN with instr_valid=1. The decision is combinational in that cycle; state updates at the next rising edge. Priority, highest first:
  1. illegal_instr: cause 32'd2.
  2. ecall: cause 32'd11.
  3. irq_pend: cause 32'h8000_000B.
  4. mret.
- Trap entry (priorities 1-3):
  - pc_src_sel=4 and trap_taken=1 in the event cycle.
  - At the edge: mepc<=pc_addr with [1:0]=0; mcause<=cause; MPIE<=MIE; MIE<=0.
  - For an interrupt, the instruction at pc_addr is treated as not executed, so its csr_we is suppressed.
- mret:
  - pc_src_sel=5 in the event cycle; the mepc output is the pre-update value.
  - At the edge: MIE<=MPIE; MPIE<=1.
  - No trap_taken pulse.
- Otherwise pc_src_sel=0. The PC's branch and jal selects are driven by the control unit; this block's output is OR-merged only when nonzero.
- irq_pend with instr_valid=0 is held pending, not lost, until the next instr_valid in RUN.
- CSR map (reads combinational; unmapped addresses read 0 and ignore writes):
  - 0x300 mstatus: only bit 3 (MIE) and bit 7 (MPIE) are implemented.
  - 0x304 mie: only bit 11 (MEIE) is implemented.
  - 0x305 mtvec: bits [1:0] forced 0.
  - 0x341 mepc: bits [1:0] forced 0.
  - 0x342 mcause: writable.
  - 0x344 mip: read-only; bit 11 = intr_s.
  - 0xB00 / 0xB80: mcycle low / high words.
- Write conflicts:
  - A CSR write in the same cycle as a trap or mret loses to the hardware update for mstatus, mepc and mcause.
  - Writes to other CSRs in that cycle proceed, except when the event is an interrupt (writes suppressed as above).
- mcycle: 64-bit counter, increments every cycle and wraps from all-ones to 0.
  - A write to a half replaces that half on that edge; that cycle's increment is discarded.
  - Carry between halves is computed on the full 64-bit value.

Decomposition:
- Shared package trap_pkg holds:
  - CSR address constants.
  - PC select encodings (PCSEL_NEXT=0, PCSEL_JALR=1, PCSEL_BRANCH=2, PCSEL_JAL=3, PCSEL_MTVEC=4, PCSEL_MEPC=5), used by both the control unit and this block.
  - Cause codes.
  - FSM state enum.
- Sub-module irq_sync: parameterised flop chain of depth SYNC_STAGES, reset to 0.

Test Plan:
- Reset: release rst_n -> mtvec=MTVEC_RESET, mepc=0, pc_src_sel=0, flush=0. Read 0x300 -> 0.
- Illegal instruction: write mtvec=0x104, then illegal_instr with pc_addr=0x40 -> pc_src_sel=4, trap_taken=1 that cycle. Next cycle: mepc=0x40, mcause=2, flush=1.
- Interrupt: MIE=1, mie[11]=1, intr raised. After 2 cycles, next instr_valid at pc_addr=0x80 -> mcause=0x8000000B, mepc=0x80, MIE=0, MPIE=1. intr held with MIE=0 -> no second trap.
- mret: with MPIE=1 and mepc=0x80, mret -> pc_src_sel=5, mtvec/mepc unchanged. Then MIE=1, MPIE=1.
- Simultaneous events:
  - illegal_instr, ecall and a pending interrupt in one cycle -> mcause=2.
  - csr_we to mepc=0x200 during an ecall at 0x60 -> mepc=0x60.
  - Event during FLUSH -> ignored.
- mcycle: write 0xB00=0xFFFFFFFF, 0xB80=0 -> two cycles later reads high=1, low=0.
